sym_seq_arbiter: RTL

- Schedules and sequences a shared 2-bit symbol recognizer: a 4-state FSM with input s, recognized state st3 = 2'b11, and an active-low reset.
- Two requesters compete for the recognizer. The arbiter grants it to one of them, clears the recognizer, and forwards that requester's symbols for one complete sequence. It then reports whether st3 was reached.
- Sits between the symbol sources and the recognizer instance. It owns the recognizer's s input and reset.

---
 rtl/sym_seq_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/sym_seq_arbiter.sv
// Two-requester arbiter that owns a shared 2-bit symbol recognizer: grants it,
// clears it, forwards one symbol sequence, then reports whether st3 was reached.
module sym_seq_arbiter #(
  parameter int TIMEOUT = 12,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       res,
  input  logic       req0,
  input  logic [1:0] sym0,
  input  logic       last0,
  input  logic       req1,
  input  logic [1:0] sym1,
  input  logic       last1,
  input  logic [1:0] state_in,
  output logic       gnt0,
  output logic       gnt1,
  output logic [1:0] s_out,
  output logic       rec_res,
  output logic       done,
  output logic       match,
  output logic       owner,
  output logic       timeout
);

  // state  | meaning
  // IDLE   | recognizer idle, waiting for a request
  // CLR    | recognizer held in reset for one cycle
  // RUN    | forwarding owner symbols, counting cycles
  // DRAIN1 | final symbol propagating through recognizer
  // DRAIN2 | last match sample, then report and release
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CLR    = 3'd1;
  localparam logic [2:0] RUN    = 3'd2;
  localparam logic [2:0] DRAIN1 = 3'd3;
  localparam logic [2:0] DRAIN2 = 3'd4;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             own_q, own_d;
  logic             rr_q, rr_d;
  logic             hit_q, hit_d;
  logic             tmo_q, tmo_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic [1:0]       s_out_q, s_out_d;
  logic             rec_res_q, rec_res_d;
  logic             done_q, done_d;
  logic             match_q, match_d;
  logic             owner_q, owner_d;
  logic             timeout_q, timeout_d;

  logic       own_req, own_last, st3, pick;
  logic [1:0] own_sym;

  assign own_req  = own_q ? req1  : req0;
  assign own_sym  = own_q ? sym1  : sym0;
  assign own_last = own_q ? last1 : last0;
  assign st3      = (state_in == 2'b11);
  // with both requesting, the one not served last wins
  assign pick     = (req0 && req1) ? ~rr_q : req1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    own_d     = own_q;
    rr_d      = rr_q;
    hit_d     = hit_q;
    tmo_d     = tmo_q;
    gnt0_d    = gnt0_q;
    gnt1_d    = gnt1_q;
    s_out_d   = 2'b00;
    rec_res_d = 1'b1;
    done_d    = 1'b0;
    match_d   = 1'b0;
    owner_d   = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt0_d  = ~pick;
          gnt1_d  = pick;
          own_d   = pick;
          hit_d   = 1'b0;
          tmo_d   = 1'b0;
          cnt_d   = '0;
          state_d = CLR;
        end
      end
      CLR: begin
        rec_res_d = 1'b0;
        state_d   = RUN;
      end
      RUN: begin
        cnt_d   = cnt_q + 1'b1;
        s_out_d = own_req ? own_sym : 2'b00;
        if (st3) hit_d = 1'b1;
        if (own_req && own_last) begin
          state_d = DRAIN1;
        end else if (cnt_q == CNT_LAST) begin
          tmo_d   = 1'b1;
          state_d = DRAIN1;
        end
      end
      DRAIN1: begin
        if (st3) hit_d = 1'b1;
        state_d = DRAIN2;
      end
      DRAIN2: begin
        // include this cycle's sample so a late st3 still counts
        done_d    = 1'b1;
        match_d   = hit_q | st3;
        owner_d   = own_q;
        timeout_d = tmo_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        rr_d      = own_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      own_q     <= 1'b0;
      rr_q      <= 1'b1;
      hit_q     <= 1'b0;
      tmo_q     <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      s_out_q   <= 2'b00;
      rec_res_q <= 1'b0;
      done_q    <= 1'b0;
      match_q   <= 1'b0;
      owner_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      own_q     <= own_d;
      rr_q      <= rr_d;
      hit_q     <= hit_d;
      tmo_q     <= tmo_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      s_out_q   <= s_out_d;
      rec_res_q <= rec_res_d;
      done_q    <= done_d;
      match_q   <= match_d;
      owner_q   <= owner_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign s_out   = s_out_q;
  assign rec_res = rec_res_q;
  assign done    = done_q;
  assign match   = match_q;
  assign owner   = owner_q;
  assign timeout = timeout_q;

endmodule
